fifo_stream_reader: RTL and testbench

Downstream consumer of the synchronous FIFO. It drives the FIFO read port (`rd_en`/`empty`/`data_out`) and presents the words as a valid/ready stream to the next stage of the delay line. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so back-to-back transfers sustain 1 word/cycle without dropping or duplicating words. It also provides a synchronous flush and a transfer counter.

---
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words from a synchronous FIFO and presents them
// as a valid/ready stream. A 2-entry buffer hides the FIFO's one-cycle read
// latency so back-to-back transfers run at one word per cycle.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_rd_en,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic             inflight;
    logic             pop;
    logic             capture;
    logic [2:0]       proj;   // occupancy at end of cycle if nothing new is requested

    assign pop      = out_valid & out_ready;
    // pop implies cnt >= 1, so this never underflows
    assign proj     = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = n_reset & ~flush & ~fifo_empty & (proj < 3'd2);
    // a flush discards the word arriving from the FIFO this cycle
    assign capture  = inflight & ~flush;
    assign out_data = slot0;

    // next occupancy from capture/pop, forced empty on flush
    always_comb begin
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = 2'd0;
        end else begin
            case ({capture, pop})
                2'b10:   cnt_nxt = cnt + 2'd1;
                2'b01:   cnt_nxt = cnt - 2'd1;
                default: cnt_nxt = cnt;
            endcase
        end
    end

    // occupancy, in-flight tracking, registered valid and transfer counter
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt        <= 2'd0;
            inflight   <= 1'b0;
            out_valid  <= 1'b0;
            xfer_count <= '0;
        end else begin
            cnt       <= cnt_nxt;
            inflight  <= fifo_rd_en;
            out_valid <= (cnt_nxt != 2'd0);
            if (pop)
                xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // buffer slots; slot0 only changes when a new head word exists, so
    // out_data holds its last value while the buffer is empty
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot0 <= '0;
            slot1 <= '0;
        end else if (capture) begin
            if (cnt == 2'd0 || (pop && cnt == 2'd1)) begin
                slot0 <= fifo_data;
            end else if (pop) begin
                slot0 <= slot1;
                slot1 <= fifo_data;
            end else begin
                slot1 <= fifo_data;
            end
        end else if (pop && cnt == 2'd2) begin
            slot0 <= slot1;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO and a
// scoreboard of expected output words.
module tb_fifo_stream_reader;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          fifo_rd_en;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] xfer_count;

    fifo_stream_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [W-1:0] fq[$];   // FIFO contents
    logic [W-1:0] eq[$];   // words expected on the stream, in order

    int tick_n, first_rd, first_vld, first_pop, last_pop, pop_cnt, rd_cnt;
    logic have_prev, prev_vld, prev_rdy, prev_flush;
    logic [W-1:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        tick_n = 0; first_rd = -1; first_vld = -1; first_pop = -1;
        last_pop = -1; pop_cnt = 0; rd_cnt = 0; have_prev = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        eq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // entered at posedge+1; samples mid-cycle, advances one clock, models FIFO pop
    task automatic tick();
        logic rd, v, pp;
        logic [W-1:0] d, e;
        #2;
        rd = fifo_rd_en; v = out_valid; pp = out_valid & out_ready; d = out_data;
        n_chk++;
        assert (int'(dut.cnt) + int'(dut.inflight) <= 2) else begin
            n_fail++;
            $error("FAIL occupancy: observed %0d expected <=2", int'(dut.cnt) + int'(dut.inflight));
        end
        if (have_prev && prev_vld && !prev_rdy && !prev_flush) begin
            chk("hold_valid", {31'd0, v}, 32'd1);
            chk("hold_data", {24'd0, d}, {24'd0, prev_data});
        end
        if (rd && first_rd < 0) first_rd = tick_n;
        if (v && first_vld < 0) first_vld = tick_n;
        if (rd) rd_cnt++;
        if (pp) begin
            if (pop_cnt == 0) first_pop = tick_n;
            last_pop = tick_n;
            pop_cnt++;
            n_chk++;
            assert (eq.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_word: observed %0h expected none", d);
            end
            if (eq.size() != 0) begin
                e = eq.pop_front();
                chk("word", {24'd0, d}, {24'd0, e});
            end
        end
        have_prev = 1'b1; prev_vld = v; prev_rdy = out_ready;
        prev_flush = flush; prev_data = d;
        @(posedge clk); #1;
        if (rd && fq.size() != 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
        tick_n++;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        fq.delete(); eq.delete();
        fifo_empty = 1'b1; fifo_data = '0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        n_reset = 1'b1;
        clr_stats();
    endtask

    initial begin
        n_reset = 1'b1; fifo_empty = 1'b1; fifo_data = '0;
        out_ready = 1'b0; flush = 1'b0;
        clr_stats();
        #1 n_reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_xfer", {28'd0, xfer_count}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        fifo_empty = 1'b0;   // rd_en must stay low in reset even with data available
        #1;
        chk("rst_rd_gated", {31'd0, fifo_rd_en}, 32'd0);

        // 1: streaming at full rate
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(8'h11 + i[7:0]);
        for (int i = 0; i < 14; i++) tick();
        chk("t1_first_rd", first_rd, 0);
        chk("t1_latency", first_vld - first_rd, 2);
        chk("t1_pops", pop_cnt, 10);
        chk("t1_consec", last_pop - first_pop, 9);
        chk("t1_xfer", {28'd0, xfer_count}, 10);
        chk("t1_rd_low", {31'd0, fifo_rd_en}, 32'd0);
        chk("t1_drained", eq.size(), 0);

        // 2: backpressure then release
        do_reset();
        for (int i = 0; i < 10; i++) push(8'h21 + i[7:0]);
        for (int i = 0; i < 8; i++) tick();
        chk("t2_rd_pulses", rd_cnt, 2);
        chk("t2_head", {24'd0, out_data}, 32'h21);
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_rd_low", {31'd0, fifo_rd_en}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("t2_pops", pop_cnt, 10);
        chk("t2_drained", eq.size(), 0);
        chk("t2_xfer", {28'd0, xfer_count}, 10);

        // 3: random ready over 200 random words
        do_reset();
        for (int i = 0; i < 200; i++) push(W'($urandom_range(0, 255)));
        for (int i = 0; i < 1500 && eq.size() != 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t3_drained", eq.size(), 0);
        chk("t3_pops", pop_cnt, 200);
        chk("t3_xfer", {28'd0, xfer_count}, 200 % 16);

        // 4: flush with one word buffered and one in flight
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h31 + i[7:0]);
        tick(); tick();
        flush = 1'b1;
        #1;
        chk("t4_rd_in_flush", {31'd0, fifo_rd_en}, 32'd0);
        tick();
        flush = 1'b0;
        chk("t4_valid_after", {31'd0, out_valid}, 32'd0);
        void'(eq.pop_front());   // 0x31 was buffered
        void'(eq.pop_front());   // 0x32 was in flight
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t4_pops", pop_cnt, 3);
        chk("t4_drained", eq.size(), 0);
        chk("t4_xfer", {28'd0, xfer_count}, 3);

        // 5: counter wrap with 4-bit counter
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h40 + i[7:0]);
        for (int i = 0; i < 40 && pop_cnt < 16; i++) tick();
        chk("t5_wrap0", {28'd0, xfer_count}, 0);
        for (int i = 0; i < 40 && pop_cnt < 17; i++) tick();
        chk("t5_wrap1", {28'd0, xfer_count}, 1);
        chk("t5_pops", pop_cnt, 17);

        // 6: asynchronous reset mid-stream
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'h51 + i[7:0]);
        for (int i = 0; i < 4; i++) tick();
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        n_reset = 1'b0;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("t6_xfer", {28'd0, xfer_count}, 0);
        chk("t6_data", {24'd0, out_data}, 32'd0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
